// File: rtl/cmsdk_apb_master_pkg.sv
// Shared encodings for the APB command master: FSM states and response codes.
package cmsdk_apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Outcome of one APB transfer; folded into rsp_err / rsp_timeout.
    typedef enum logic [1:0] {
        RSP_OKAY    = 2'd0,
        RSP_SLVERR  = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_code_t;

endpackage

// File: rtl/cmsdk_apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers
// and returns read data and status on a valid/ready response stream.
module cmsdk_apb_cmd_master
    import cmsdk_apb_master_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-3:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-3:0] PADDR,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam bit               TO_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-3:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rsp_code_t         code;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        code          = RSP_OKAY;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Completion wins over abort when both happen in the same cycle.
                if (PREADY) begin
                    code          = PSLVERR ? RSP_SLVERR : RSP_OKAY;
                    rsp_rdata_d   = pwrite_q ? 32'd0 : PRDATA;
                    rsp_err_d     = (code != RSP_OKAY);
                    rsp_timeout_d = (code == RSP_TIMEOUT);
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN && (cnt_q == TO_LIM)) begin
                    code          = RSP_TIMEOUT;
                    rsp_rdata_d   = 32'd0;
                    rsp_err_d     = (code != RSP_OKAY);
                    rsp_timeout_d = (code == RSP_TIMEOUT);
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_cmsdk_apb_cmd_master.sv
// Directed bench for cmsdk_apb_cmd_master with a 4-cycle wait-state timeout.
module tb_cmsdk_apb_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;

    int n_checks = 0;
    int n_pass   = 0;

    cmsdk_apb_cmd_master #(.ADDR_W(12), .TIMEOUT(4), .CNT_W(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        n_checks++; if (PSEL !== 1'b0) $display("FAIL reset_psel got %b want 0", PSEL); else n_pass++;
        n_checks++; if (PENABLE !== 1'b0) $display("FAIL reset_penable got %b want 0", PENABLE); else n_pass++;
        n_checks++; if (PWRITE !== 1'b0) $display("FAIL reset_pwrite got %b want 0", PWRITE); else n_pass++;
        n_checks++; if (PADDR !== 10'h000) $display("FAIL reset_paddr got %h want 000", PADDR); else n_pass++;
        n_checks++; if (PWDATA !== 32'h0) $display("FAIL reset_pwdata got %h want 0", PWDATA); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); else n_pass++;
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00) $display("FAIL reset_rsp_status got %b want 00", {rsp_err, rsp_timeout}); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else n_pass++;
        PRESET = 1'b0;
        tick();
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL hs_rsp_valid got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL hs_cmd_ready got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_zero_wait_read();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h3F8; cmd_wdata = 32'h0;
        PREADY = 1'b1; PRDATA = 32'h23; PSLVERR = 1'b0;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if ({PSEL, PENABLE} !== 2'b10) $display("FAIL zw_setup got %b want 10", {PSEL, PENABLE}); else n_pass++;
        n_checks++; if (PADDR !== 10'h3F8) $display("FAIL zw_paddr got %h want 3f8", PADDR); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL zw_cmd_ready got %b want 0", cmd_ready); else n_pass++;
        tick();
        n_checks++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL zw_access got %b want 11", {PSEL, PENABLE}); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL zw_rsp_valid got %b want 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h00000023) $display("FAIL zw_rdata got %h want 00000023", rsp_rdata); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL zw_err got %b want 0", rsp_err); else n_pass++;
        n_checks++; if ({PSEL, PENABLE} !== 2'b00) $display("FAIL zw_bus_idle got %b want 00", {PSEL, PENABLE}); else n_pass++;
        handshake();
    endtask

    task automatic test_write_wait();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h002; cmd_wdata = 32'h000000E2;
        PREADY = 1'b0; PRDATA = 32'h55; PSLVERR = 1'b0;
        tick();
        cmd_valid = 1'b0; cmd_wdata = 32'hFFFFFFFF; cmd_addr = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (PSEL !== 1'b1) $display("FAIL ww_psel cyc %0d got %b want 1", i, PSEL); else n_pass++;
            n_checks++; if (PENABLE !== (i != 0)) $display("FAIL ww_penable cyc %0d got %b want %b", i, PENABLE, (i != 0)); else n_pass++;
            n_checks++; if ({PWRITE, PADDR, PWDATA} !== {1'b1, 10'h002, 32'h000000E2})
                $display("FAIL ww_addr_data cyc %0d got %b/%h/%h want 1/002/000000e2", i, PWRITE, PADDR, PWDATA); else n_pass++;
            if (i == 4) PREADY = 1'b1;
            tick();
        end
        PREADY = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL ww_rsp_valid got %b want 1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL ww_rdata got %h want 0", rsp_rdata); else n_pass++;
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00) $display("FAIL ww_status got %b want 00", {rsp_err, rsp_timeout}); else n_pass++;
        n_checks++; if (PSEL !== 1'b0) $display("FAIL ww_psel_drop got %b want 0", PSEL); else n_pass++;
        n_checks++; if (PWDATA !== 32'h000000E2) $display("FAIL ww_pwdata_hold got %h want 000000e2", PWDATA); else n_pass++;
        handshake();
    endtask

    task automatic test_slverr();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h010;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL se_rsp_valid got %b want 1", rsp_valid); else n_pass++;
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b10) $display("FAIL se_status got %b want 10", {rsp_err, rsp_timeout}); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL se_rdata got %h want deadbeef", rsp_rdata); else n_pass++;
        PSLVERR = 1'b0;
        handshake();
    endtask

    task automatic test_timeout(input bit late_ready);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h020;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hCAFE0001;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({PSEL, PENABLE} !== 2'b11) $display("FAIL to_access late=%0d cyc %0d got %b want 11", late_ready, i, {PSEL, PENABLE}); else n_pass++;
            if (late_ready && i == 4) PREADY = 1'b1;
            tick();
        end
        PREADY = 1'b0;
        n_checks++; if ({PSEL, PENABLE} !== 2'b00) $display("FAIL to_bus_drop late=%0d got %b want 00", late_ready, {PSEL, PENABLE}); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL to_rsp_valid late=%0d got %b want 1", late_ready, rsp_valid); else n_pass++;
        if (late_ready) begin
            n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00) $display("FAIL to_late_status got %b want 00", {rsp_err, rsp_timeout}); else n_pass++;
            n_checks++; if (rsp_rdata !== 32'hCAFE0001) $display("FAIL to_late_rdata got %h want cafe0001", rsp_rdata); else n_pass++;
        end else begin
            n_checks++; if ({rsp_err, rsp_timeout} !== 2'b11) $display("FAIL to_abort_status got %b want 11", {rsp_err, rsp_timeout}); else n_pass++;
            n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL to_abort_rdata got %h want 0", rsp_rdata); else n_pass++;
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h044;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h11111111;
        tick();
        cmd_write = 1'b1; cmd_addr = 10'h155; cmd_wdata = 32'hA5A5A5A5;
        tick();
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bb_ready_access got %b want 0", cmd_ready); else n_pass++;
        tick();
        PRDATA = 32'h99999999;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 32'h11111111, 2'b00})
                $display("FAIL bb_rsp_hold cyc %0d got %b/%h/%b%b want 1/11111111/00", i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout); else n_pass++;
            n_checks++; if ({cmd_ready, PSEL} !== 2'b00) $display("FAIL bb_stall cyc %0d got %b want 00", i, {cmd_ready, PSEL}); else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++; if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) $display("FAIL bb_idle got %b want 100", {cmd_ready, rsp_valid, PSEL}); else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b101) $display("FAIL bb_second_setup got %b want 101", {PSEL, PENABLE, PWRITE}); else n_pass++;
        n_checks++; if ({PADDR, PWDATA} !== {10'h155, 32'hA5A5A5A5}) $display("FAIL bb_second_cmd got %h/%h want 155/a5a5a5a5", PADDR, PWDATA); else n_pass++;
        tick();
        tick();
        n_checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0}) $display("FAIL bb_second_rsp got %b/%h want 1/0", rsp_valid, rsp_rdata); else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h0C0;
        PREADY = 1'b0; PSLVERR = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        PREADY = 1'b1;
        n_checks++; if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) $display("FAIL rm_after got %b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready}); else n_pass++;
        n_checks++; if (PADDR !== 10'h000) $display("FAIL rm_paddr got %h want 000", PADDR); else n_pass++;
        tick();
        tick();
        n_checks++; if ({PSEL, rsp_valid} !== 2'b00) $display("FAIL rm_no_rsp got %b want 00", {PSEL, rsp_valid}); else n_pass++;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h0AB; PRDATA = 32'h12345678;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if ({PSEL, PADDR} !== {1'b1, 10'h0AB}) $display("FAIL rm_next_setup got %b/%h want 1/0ab", PSEL, PADDR); else n_pass++;
        tick();
        tick();
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h12345678}) $display("FAIL rm_next_rsp got %b%b/%h want 10/12345678", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
        handshake();
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_slverr();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cmsdk_apb_cmd_master.md
Name: cmsdk_apb_cmd_master

Overview:
- APB3 initiator. Converts a simple valid/ready command stream (read/write, word address, write data) into single APB transfers.
- Returns read data plus error status on a valid/ready response stream.
- Drives CMSDK APB slaves such as the dual timers from a DMA engine or test sequencer.
- One transfer in flight. Bounded wait-state timeout so a hung slave cannot lock the bus.

Parameters:
- ADDR_W, 12: APB byte-address width. PADDR carries bits [ADDR_W-1:2].
- TIMEOUT, 255: maximum ACCESS-phase wait cycles with PREADY low before abort. 0 disables the timeout.
- CNT_W, 8: timeout counter width. Requires TIMEOUT < 2**CNT_W.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W-2  word address, bits [ADDR_W-1:2].
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and for aborted transfers.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_W-2  APB address [ADDR_W-1:2].
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  slave ready. Tie high for APB2 slaves.
- PSLVERR  in  1  slave error. Tie low if unused.

Behaviour:
- Reset (PRESET high at a PCLK edge):
  - state goes to IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout all 0.
  - PADDR, PWDATA, rsp_rdata all 0.
  - Timeout counter 0.
- All outputs are registered, except cmd_ready = (state == IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: on cmd_valid & cmd_ready, capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP. Otherwise stay in IDLE.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - If PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0. Drop PSEL and PENABLE. Go to RESP.
    - Else if TIMEOUT != 0 and the counter equals TIMEOUT: drop PSEL and PENABLE, set rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1. Go to RESP.
    - Else increment the counter.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE next cycle and clear rsp_valid. rsp_* fields stay stable while rsp_valid is high.
- Timeout counter clears on every entry to SETUP. It counts only ACCESS cycles where PREADY=0.
  - An abort occurs after exactly TIMEOUT+1 ACCESS cycles with PREADY low.
  - PREADY=1 in the same cycle the counter reaches TIMEOUT is a normal completion; completion has priority over abort.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They hold their value while idle; they change only on command accept.
- Latency, accept at edge 0 with a zero-wait slave:
  - SETUP visible in cycle 1.
  - ACCESS in cycle 2.
  - rsp_valid in cycle 3.
- Minimum issue rate: 4 cycles per command, counting the IDLE cycle after the response handshake.
- cmd_ready stays low from accept until return to IDLE. It never combinationally depends on rsp_ready.
- PRESET asserted mid-transfer: next edge goes to IDLE and drops PSEL/PENABLE. The in-flight command and any pending response are discarded; no rsp_valid is produced.
- APB protocol rules: PENABLE is never high without PSEL. PSEL never drops between SETUP and the completing ACCESS cycle, except on abort or reset.

Decomposition:
- Shared package cmsdk_apb_master_pkg:
  - state encoding constants: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3.
  - response-code constants: OKAY, SLVERR, TIMEOUT.
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- Zero-wait read, cmd_addr=0x3F8 (byte 0xFE0), slave returns 0x23:
  - PSEL rises cycle 1, PENABLE cycle 2.
  - rsp_valid cycle 3 with rsp_rdata=0x00000023, rsp_err=0.
- Write 0x000000E2 to addr 0x002, slave inserts 3 wait states:
  - PWDATA/PADDR stable for 5 PSEL cycles.
  - rsp_valid 1 cycle after PREADY, with rsp_rdata=0 and rsp_err=0.
- Read where the slave drives PREADY=1 with PSLVERR=1 and PRDATA=0xDEADBEEF:
  - rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEADBEEF.
- TIMEOUT=4, slave never ready:
  - ACCESS lasts exactly 5 cycles, then PSEL=PENABLE=0.
  - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with PREADY=1 on the 5th ACCESS cycle: normal completion, rsp_timeout=0.
- rsp_ready held low 10 cycles, with cmd_valid held high by a second command:
  - rsp fields stable.
  - cmd_ready=0 throughout.
  - Second SETUP begins 2 cycles after the rsp handshake.
- PRESET pulsed during ACCESS:
  - Next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1.
  - A following read completes normally.
